step_dda_multi: RTL and testbench
=================================

// Module: step_dda_multi
// PURPOSE
//  Multi-channel DDA step/direction pulse generator for the stepper axes.
//  Per frame, each channel receives a signed step count. It spreads that many evenly
//  spaced fixed-width step pulses across the frame. Commands arriving mid-frame are
//  double-buffered and applied at the next frame boundary, so consecutive frames run gap-free.
//  Sits between the command bus write strobe and the per-axis driver outputs.
// PARAMETERS
//  NCH          3    number of channels (axes)
//  CMD_W        8    per-channel command width; MSB = dir, [CMD_W-2:0] = magnitude
//  TICK_DIV     400  clk cycles per tick (20 us at 20 MHz); step pulse high time = 1 tick
//  FRAME_TICKS  500  ticks per frame (10 ms); must be even; NMAX = FRAME_TICKS/2 pulse slots
//  POS_W        32   position counter width (POS_CNT_EN only)
// PORTS
//  clk    in   1          system clock
//  rst    in   1          asynchronous reset, active-high
//  wr_n   in   1          write strobe, active-low; a load occurs on its falling edge
//  cmd    in   NCH*CMD_W  channel k = cmd[k*CMD_W +: CMD_W]
//  pulse  out  NCH        step pulse per channel
//  dir    out  NCH        direction per channel (1 = negative)
//  busy   out  1          frame in progress
//  pend   out  1          shadow command waiting for the frame boundary
//  pos    out  NCH*POS_W  signed position per channel; driven 0 without POS_CNT_EN
// BEHAVIOUR
//  - Reset: pulse=0, dir=0, busy=0, pend=0, pos=0. All counters, accumulators and shadow registers clear.
//    An async assert aborts a frame immediately, including mid-pulse.
//  - Load event: wr_d registered from wr_n (reset value 1); load = wr_d & ~wr_n (one cycle).
//    Holding wr_n low produces exactly one load.
//  - Idle load at cycle t: active cmd, dir, busy=1 all valid at t+1.
//    Prescaler=0, tick_cnt=0, acc=0 for every channel.
//  - Magnitude m = cmd[CMD_W-2:0], clamped to NMAX if larger.
//  - Prescaler counts 0..TICK_DIV-1; tick fires at TICK_DIV-1. tick_cnt counts 0..FRAME_TICKS-1.
//  - Tick with even tick_cnt (slot s = tick_cnt/2), per channel:
//      acc += m;
//      if acc >= NMAX: acc -= NMAX, pulse = 1.
//  - Tick with odd tick_cnt: pulse = 0. Pulse width is exactly TICK_DIV clk.
//  - Over NMAX slots, exactly m pulses are emitted; the last falls on slot NMAX-1 when m > 0.
//    m = 0 gives no pulses; m = NMAX gives a pulse every slot.
//  - acc width = clog2(2*NMAX), with no overflow possible.
//  - dir changes only at frame load, and pulse is 0 at every frame load.
//    dir leads the first rising edge by >= TICK_DIV clk.
//  - Load while busy: shadow <= cmd, pend=1. A later load before the boundary overwrites the shadow (last wins).
//  - Frame end (tick at tick_cnt = FRAME_TICKS-1):
//      pend = 1: load shadow, pend=0, busy stays 1, new frame starts next cycle with no gap.
//      pend = 0: busy=0, counters hold at 0.
//  - Load coincident with frame end: cmd bypasses the shadow and becomes the next frame; pend stays 0.
//  - Shadow resolution applies to all channels simultaneously (single busy/pend, shared timebase).
// CONFIGURATION
//  - POS_CNT_EN defined:
//      pos[k] += 1 on each rising edge of pulse[k] when dir[k] = 0; pos[k] -= 1 when dir[k] = 1.
//      Two's-complement wrap at POS_W; only rst clears it. Frame loads do not clear it.
//  - POS_CNT_EN undefined: no counters synthesised; pos tied to 0.
// TESTING  (bench params: TICK_DIV=4, FRAME_TICKS=20 -> NMAX=10, NCH=3, CMD_W=8)
//  - ch0=0x05, ch1=0x00, ch2=0x0A, idle load
//      -> ch0: pulses in slots 1,3,5,7,9, each 4 clk high.
//      -> ch1: none.
//      -> ch2: 10 pulses.
//      -> busy high for 80 clk.
//  - ch0=0x8A with POS_CNT_EN -> dir0=1 from cycle t+1, 10 pulses, pos0 = -10 at frame end.
//  - ch0=0x7F -> clamped to 10 pulses in the frame.
//  - Load 0x03, then 0x04 at tick 6, then 0x02 at tick 12
//      -> pend=1 after the second load.
//      -> frame 2 emits 2 pulses on ch0.
//      -> busy continuous across the boundary; pend=0 at frame 2 start.
//  - Load coincident with the frame-end tick -> next frame uses the new cmd, pend never asserts.
//  - rst pulsed during a high pulse -> pulse/busy/pend/pos drop to 0 asynchronously.
//    A subsequent load starts with acc=0.
//  - wr_n held low for 50 clk from idle -> exactly one load; one frame; busy drops after 80 clk.

Source files
------------

// File: rtl/step_dda_multi.sv
// Multi-channel DDA step/direction generator: per-frame signed step counts, double-buffered.
// Optional feature: define POS_CNT_EN to build signed per-channel position counters on pos.
`timescale 1ns/1ps
module step_dda_multi #(
  parameter int NCH         = 3,
  parameter int CMD_W       = 8,
  parameter int TICK_DIV    = 400,
  parameter int FRAME_TICKS = 500,
  parameter int POS_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_n,
  input  logic [NCH*CMD_W-1:0]   cmd,
  output logic [NCH-1:0]         pulse,
  output logic [NCH-1:0]         dir,
  output logic                   busy,
  output logic                   pend,
  output logic [NCH*POS_W-1:0]   pos
);

  localparam int NMAX    = FRAME_TICKS / 2;
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TICK_W  = $clog2(FRAME_TICKS);
  localparam int M_W     = $clog2(NMAX + 1);
  localparam int ACC_W   = $clog2(2 * NMAX);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [ACC_W-1:0]   NMAX_ACC   = ACC_W'(NMAX);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               state_q, state_d;
  logic                 pend_q, pend_d;
  logic                 wr_d_q, wr_d_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [NCH-1:0]       dir_q, dir_d;
  logic [NCH-1:0]       pulse_q, pulse_d;
  logic [NCH*CMD_W-1:0] shadow_q, shadow_d;
  logic [M_W-1:0]       mag_q [NCH];
  logic [M_W-1:0]       mag_d [NCH];
  logic [ACC_W-1:0]     acc_q [NCH];
  logic [ACC_W-1:0]     acc_d [NCH];
  logic [NCH*CMD_W-1:0] start_cmd;
  logic                 load, tick, frame_end, start;

  function automatic logic [M_W-1:0] clamp_mag(input logic [CMD_W-2:0] raw);
    if (int'(raw) > NMAX) return M_W'(NMAX);
    else return M_W'(raw);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      wr_d_q   <= 1'b1;
      presc_q  <= '0;
      tick_q   <= '0;
      dir_q    <= '0;
      pulse_q  <= '0;
      shadow_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        mag_q[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      wr_d_q   <= wr_d_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      dir_q    <= dir_d;
      pulse_q  <= pulse_d;
      shadow_q <= shadow_d;
      for (int k = 0; k < NCH; k++) begin
        mag_q[k] <= mag_d[k];
        acc_q[k] <= acc_d[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    wr_d_d    = wr_n;
    presc_d   = presc_q;
    tick_d    = tick_q;
    dir_d     = dir_q;
    pulse_d   = pulse_q;
    shadow_d  = shadow_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    start     = 1'b0;
    start_cmd = cmd;
    load      = wr_d_q & ~wr_n;
    tick      = (state_q == S_RUN) && (presc_q == PRESC_LAST);
    frame_end = tick && (tick_q == TICK_LAST);

    if (state_q == S_IDLE) begin
      start = load;
    end else begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      if (tick) begin
        tick_d = tick_q + TICK_W'(1);
        // Even ticks are pulse slots; acc + m >= NMAX is tested as acc >= NMAX - m to stay in ACC_W bits
        for (int k = 0; k < NCH; k++) begin
          if (tick_q[0]) begin
            pulse_d[k] = 1'b0;
          end else if (acc_q[k] >= NMAX_ACC - ACC_W'(mag_q[k])) begin
            acc_d[k]   = acc_q[k] + ACC_W'(mag_q[k]) - NMAX_ACC;
            pulse_d[k] = 1'b1;
          end else begin
            acc_d[k] = acc_q[k] + ACC_W'(mag_q[k]);
          end
        end
      end
      if (frame_end) begin
        pend_d = 1'b0;
        if (load) begin
          start = 1'b1;
        end else if (pend_q) begin
          start     = 1'b1;
          start_cmd = shadow_q;
        end else begin
          state_d = S_IDLE;
          presc_d = '0;
          tick_d  = '0;
        end
      end else if (load) begin
        shadow_d = cmd;
        pend_d   = 1'b1;
      end
    end

    if (start) begin
      state_d = S_RUN;
      presc_d = '0;
      tick_d  = '0;
      pulse_d = '0;
      for (int k = 0; k < NCH; k++) begin
        acc_d[k] = '0;
        mag_d[k] = clamp_mag(start_cmd[k*CMD_W +: CMD_W-1]);
        dir_d[k] = start_cmd[k*CMD_W + CMD_W - 1];
      end
    end
  end

  assign pulse = pulse_q;
  assign dir   = dir_q;
  assign busy  = (state_q == S_RUN);
  assign pend  = pend_q;

`ifdef POS_CNT_EN
  logic [POS_W-1:0] pos_q [NCH];
  logic [POS_W-1:0] pos_d [NCH];

  // Counts on the cycle the pulse rises; dir is frame-constant so dir_q is the right sign
  always_comb begin
    pos_d = pos_q;
    for (int k = 0; k < NCH; k++) begin
      if (pulse_d[k] && !pulse_q[k])
        pos_d[k] = dir_q[k] ? pos_q[k] - POS_W'(1) : pos_q[k] + POS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) pos_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) pos_q[k] <= pos_d[k];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pos
    assign pos[g*POS_W +: POS_W] = pos_q[g];
  end
`else
  assign pos = '0;
`endif

endmodule

// File: tb/tb_step_dda_multi.sv
// Scoreboard bench for step_dda_multi: a slot-arithmetic frame model queues expected pulse,
// busy and pend edges; a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_step_dda_multi;

  localparam int NCH   = 3;
  localparam int CMD_W = 8;
  localparam int TD    = 4;
  localparam int FT    = 20;
  localparam int NMAX  = FT / 2;
  localparam int POS_W = 32;
  localparam int FL    = FT * TD;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_n = 1'b1;
  logic [NCH*CMD_W-1:0] cmd = '0;
  logic [NCH-1:0]       pulse, dir;
  logic                 busy, pend;
  logic [NCH*POS_W-1:0] pos;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  step_dda_multi #(
    .NCH(NCH), .CMD_W(CMD_W), .TICK_DIV(TD), .FRAME_TICKS(FT), .POS_W(POS_W)
  ) dut (
    .clk(clk), .rst(rst), .wr_n(wr_n), .cmd(cmd),
    .pulse(pulse), .dir(dir), .busy(busy), .pend(pend), .pos(pos)
  );

  // Free-running clock and a cycle index shared by stimulus, model and monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic d;} pulse_ev_t;
  typedef struct {int rise; int fall; logic [NCH*32-1:0] posv;} busy_ev_t;
  typedef struct {int rise; int fall;} pend_ev_t;

  pulse_ev_t pulseQ [NCH][$];
  busy_ev_t  busyQ[$];
  pend_ev_t  pendQ[$];

  int modelPos [NCH];
  int mBusy, mPending, mFrameS, mBusyIdx, mPendIdx, mLastEnd;
  logic [NCH*CMD_W-1:0] mPendC;

  int loadT[$];
  int loadHold[$];
  logic [NCH*CMD_W-1:0] loadC[$];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NCH*CMD_W-1:0] randCmd();
    logic [NCH*CMD_W-1:0] c;
    int mag;
    for (int k = 0; k < NCH; k++) begin
      mag = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 12));
      c[k*CMD_W +: CMD_W-1] = 7'(mag);
      c[k*CMD_W + CMD_W - 1] = 1'($urandom_range(0, 1));
    end
    return c;
  endfunction

  // Frame model: slot s of a frame with m steps pulses iff floor((s+1)m/NMAX) > floor(sm/NMAX)
  task automatic startFrame(input int s, input logic [NCH*CMD_W-1:0] c);
    int m;
    logic d;
    pulse_ev_t ev;
    mFrameS = s;
    for (int k = 0; k < NCH; k++) begin
      m = int'(c[k*CMD_W +: CMD_W-1]);
      if (m > NMAX) m = NMAX;
      d = c[k*CMD_W + CMD_W - 1];
      for (int slot = 0; slot < NMAX; slot++) begin
        if (((slot + 1) * m) / NMAX != (slot * m) / NMAX) begin
          ev.cyc = s + 2 * slot * TD + TD;
          ev.d   = d;
          pulseQ[k].push_back(ev);
          modelPos[k] += d ? -1 : 1;
        end
      end
    end
  endtask

  task automatic closePend(input int fallCyc);
    pend_ev_t p;
    p = pendQ[mPendIdx];
    p.fall = fallCyc;
    pendQ[mPendIdx] = p;
    mPending = 0;
  endtask

  task automatic closeFrame();
    int e;
    busy_ev_t b;
    e = mFrameS + FL - 1;
    if (mPending) begin
      closePend(e + 1);
      startFrame(e + 1, mPendC);
    end else begin
      mBusy = 0;
      b = busyQ[mBusyIdx];
      b.fall = e + 1;
      for (int k = 0; k < NCH; k++) begin
`ifdef POS_CNT_EN
        b.posv[k*32 +: 32] = modelPos[k];
`else
        b.posv[k*32 +: 32] = 0;
`endif
      end
      busyQ[mBusyIdx] = b;
      mLastEnd = e + 1;
    end
  endtask

  task automatic modelLoad(input int t, input logic [NCH*CMD_W-1:0] c);
    busy_ev_t b;
    pend_ev_t p;
    while (mBusy != 0 && mFrameS + FL - 1 < t) closeFrame();
    if (mBusy == 0) begin
      mBusy    = 1;
      b.rise   = t + 1;
      b.fall   = -1;
      b.posv   = '0;
      mBusyIdx = busyQ.size();
      busyQ.push_back(b);
      startFrame(t + 1, c);
    end else if (t == mFrameS + FL - 1) begin
      if (mPending) closePend(t + 1);
      startFrame(t + 1, c);
    end else begin
      if (mPending == 0) begin
        p.rise   = t + 1;
        p.fall   = -1;
        mPendIdx = pendQ.size();
        pendQ.push_back(p);
      end
      mPending = 1;
      mPendC   = c;
    end
  endtask

  task automatic addLoad(input int t, input logic [NCH*CMD_W-1:0] c, input int hold);
    loadT.push_back(t);
    loadC.push_back(c);
    loadHold.push_back(hold);
  endtask

  task automatic applyStimulus(input int t, input logic [NCH*CMD_W-1:0] c, input int hold);
    waitCycle(t);
    cmd  = c;
    wr_n = 1'b0;
    waitCycle(t + hold);
    wr_n = 1'b1;
    cmd  = randCmd();
  endtask

  task automatic flushScoreboard();
    for (int k = 0; k < NCH; k++) pulseQ[k].delete();
    busyQ.delete();
    pendQ.delete();
  endtask

  // Builds the whole expected timeline, drives the loads, then waits for the chain to drain
  task automatic runScenario(input string name);
    int base;
    base = cyc + 3;
    for (int i = 0; i < loadT.size(); i++) modelLoad(base + loadT[i], loadC[i]);
    while (mBusy != 0) closeFrame();
    for (int i = 0; i < loadT.size(); i++) applyStimulus(base + loadT[i], loadC[i], loadHold[i]);
    waitCycle(mLastEnd + 4);
    for (int k = 0; k < NCH; k++)
      checkOutput($sformatf("%s_leftover_pulses_ch%0d", name, k), pulseQ[k].size(), 0);
    checkOutput({name, "_leftover_busy"}, busyQ.size(), 0);
    checkOutput({name, "_leftover_pend"}, pendQ.size(), 0);
    checkOutput({name, "_idle_busy"}, busy, 0);
    flushScoreboard();
    loadT.delete();
    loadC.delete();
    loadHold.delete();
  endtask

  // Monitor: compares every pulse/busy/pend edge against the queued expectation
  initial begin
    logic [NCH-1:0] prevPulse;
    logic prevBusy, prevPend;
    int riseAt [NCH];
    pulse_ev_t ev;
    busy_ev_t b;
    pend_ev_t p;
    prevPulse = '0;
    prevBusy  = 1'b0;
    prevPend  = 1'b0;
    for (int k = 0; k < NCH; k++) riseAt[k] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevPulse = '0;
        prevBusy  = 1'b0;
        prevPend  = 1'b0;
      end else begin
        for (int k = 0; k < NCH; k++) begin
          if (pulse[k] && !prevPulse[k]) begin
            if (pulseQ[k].size() == 0) begin
              checkOutput($sformatf("unexpected_pulse_ch%0d", k), cyc, -1);
            end else begin
              ev = pulseQ[k].pop_front();
              checkOutput($sformatf("pulse_rise_ch%0d", k), cyc, ev.cyc);
              checkOutput($sformatf("pulse_dir_ch%0d", k), longint'(dir[k]), longint'(ev.d));
            end
            riseAt[k] = cyc;
          end
          if (!pulse[k] && prevPulse[k])
            checkOutput($sformatf("pulse_width_ch%0d", k), cyc - riseAt[k], TD);
        end
        if (busy && !prevBusy) begin
          if (busyQ.size() == 0) checkOutput("unexpected_busy_rise", cyc, -1);
          else checkOutput("busy_rise", cyc, busyQ[0].rise);
        end
        if (!busy && prevBusy) begin
          if (busyQ.size() == 0) begin
            checkOutput("unexpected_busy_fall", cyc, -1);
          end else begin
            b = busyQ.pop_front();
            checkOutput("busy_fall", cyc, b.fall);
            for (int k = 0; k < NCH; k++)
              checkOutput($sformatf("pos_ch%0d", k), longint'($signed(pos[k*POS_W +: POS_W])),
                          longint'($signed(b.posv[k*32 +: 32])));
          end
        end
        if (pend && !prevPend) begin
          if (pendQ.size() == 0) checkOutput("unexpected_pend_rise", cyc, -1);
          else checkOutput("pend_rise", cyc, pendQ[0].rise);
        end
        if (!pend && prevPend) begin
          if (pendQ.size() == 0) begin
            checkOutput("unexpected_pend_fall", cyc, -1);
          end else begin
            p = pendQ.pop_front();
            checkOutput("pend_fall", cyc, p.fall);
          end
        end
        prevPulse = pulse;
        prevBusy  = busy;
        prevPend  = pend;
      end
    end
  end

  // Hard stop in case the DUT or bench stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    int base, t, hold, n;
    mBusy = 0; mPending = 0; mLastEnd = 0; mFrameS = 0; mBusyIdx = 0; mPendIdx = 0;
    mPendC = '0;
    for (int k = 0; k < NCH; k++) modelPos[k] = 0;

    waitCycle(3);
    checkOutput("reset_pulse", pulse, 0);
    checkOutput("reset_dir", dir, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_pend", pend, 0);
    checkOutput("reset_pos_nonzero", longint'(|pos), 0);
    rst = 1'b0;
    waitCycle(6);

    $display("[TB] mixed magnitudes from idle");
    addLoad(0, 24'h0A0005, 1);
    runScenario("mixed");

    $display("[TB] negative direction, full rate");
    addLoad(0, 24'h00008A, 1);
    runScenario("negdir");

    $display("[TB] magnitude clamp");
    addLoad(0, 24'h00007F, 1);
    runScenario("clamp");

    $display("[TB] shadow overwrite, last write wins");
    addLoad(0, 24'h000003, 1);
    addLoad(1 + 6 * TD, 24'h000004, 1);
    addLoad(1 + 12 * TD, 24'h000002, 1);
    runScenario("shadow");

    $display("[TB] load coincident with frame end");
    addLoad(0, 24'h000003, 1);
    addLoad(FL, 24'h050005, 1);
    runScenario("coincide");

    $display("[TB] pending shadow superseded by coincident load");
    addLoad(0, 24'h030201, 1);
    addLoad(30, 24'h0A0A0A, 1);
    addLoad(FL, 24'h840407, 1);
    runScenario("coincide_pend");

    $display("[TB] write strobe held low");
    addLoad(0, 24'h000006, 50);
    runScenario("hold");

    $display("[TB] async reset mid-pulse");
    base = cyc + 3;
    modelLoad(base, 24'h008A0A);
    modelLoad(base + 3, 24'h000004);
    applyStimulus(base, 24'h008A0A, 1);
    applyStimulus(base + 3, 24'h000004, 1);
    waitCycle(base + 6);
    checkOutput("pre_reset_pulse_ch0", pulse[0], 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_pulse", pulse, 0);
    checkOutput("async_rst_dir", dir, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_pend", pend, 0);
    checkOutput("async_rst_pos_nonzero", longint'(|pos), 0);
    flushScoreboard();
    mBusy = 0;
    mPending = 0;
    for (int k = 0; k < NCH; k++) modelPos[k] = 0;
    waitCycle(cyc + 3);
    rst = 1'b0;
    waitCycle(cyc + 2);
    addLoad(0, 24'h000005, 1);
    runScenario("post_reset");

    $display("[TB] randomized command sequences");
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 4);
      t = 0;
      for (int i = 0; i < n; i++) begin
        hold = $urandom_range(1, 3);
        addLoad(t, randCmd(), hold);
        t += hold + 1 + int'($urandom_range(0, 170));
      end
      runScenario($sformatf("random%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
